md_seq: RTL

- Multi-cycle sequencer for the integer multiply/divide unit of the MIPS CPU.
- Accepts MULT, MULTU, DIV and DIVU from the execute stage. Runs a 32-iteration shift-add multiply or restoring divide, and owns the HI/LO registers.
- Signed operands are reduced to magnitudes, processed unsigned, then sign-corrected. Operands arrive already sign-extended.
- Also services MTHI/MTLO writes. Drives busy so the pipeline controller can stall MFHI/MFLO and back-to-back mul/div.

---
 rtl/md_seq_pkg.sv | 31 +++
 rtl/md_datapath.sv | 124 ++++++++++++
 rtl/md_seq.sv | 119 +++++++++++
 3 files changed

// File: rtl/md_seq_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   - MD_WIDTH : default operand width (HI/LO are each this wide)
//   - op_t     : MULT/MULTU/DIV/DIVU encodings as presented on the op port
//   - state_t  : sequencer states
package md_seq_pkg;

    localparam int unsigned MD_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_t;

    function automatic logic op_is_div(input op_t o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_t o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/md_datapath.sv
// Arithmetic datapath for md_seq: operand magnitudes, the 2*WIDTH
// accumulator, one shift-add / restoring-divide iteration per step,
// and the final sign correction.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load            capture op/a/b (start accepted)
//   step            perform one iteration
//   op, a, b        operation and raw operands
//   div_by_zero     combinational: op/b presented now is a divide by zero
//   res_hi, res_lo  sign-corrected result, valid in FIX
module md_datapath
    import md_seq_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    op_t                 op_in;
    logic                sgn_op;
    logic [WIDTH-1:0]    mag_a;
    logic [WIDTH-1:0]    mag_b;

    // Mult: {upper accumulator, multiplier}. Div: {remainder, quotient}.
    logic [2*WIDTH-1:0]  acc;
    logic [WIDTH-1:0]    opnd;      // multiplicand or divisor magnitude
    logic                is_div_q;
    logic                neg_lo_q;  // negate product / quotient
    logic                neg_hi_q;  // negate remainder
    logic                dz_q;

    logic [2*WIDTH-1:0]  acc_nx;
    logic [WIDTH:0]      sum;
    logic [WIDTH:0]      rem_sh;
    logic                ge;
    logic [WIDTH-1:0]    diff;

    logic [2*WIDTH-1:0]  prod;
    logic [WIDTH-1:0]    quot;
    logic [WIDTH-1:0]    rem;

    always_comb begin
        op_in       = op_t'(op);
        sgn_op      = op_is_signed(op_in);
        mag_a       = (sgn_op && a[WIDTH-1]) ? (-a) : a;
        mag_b       = (sgn_op && b[WIDTH-1]) ? (-b) : b;
        div_by_zero = op_is_div(op_in) && (b == '0);
    end

    // One iteration. The divide compare is done on WIDTH+1 bits; when it
    // succeeds the true difference is below the divisor, so a WIDTH-bit
    // subtract yields it exactly.
    always_comb begin
        sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        ge     = (rem_sh >= {1'b0, opnd});
        diff   = rem_sh[WIDTH-1:0] - opnd;
        if (!is_div_q) begin
            acc_nx = {sum, acc[WIDTH-1:1]};
        end else if (ge) begin
            acc_nx = {diff, acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_nx = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            opnd     <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
        end else if (load) begin
            is_div_q <= op_is_div(op_in);
            dz_q     <= div_by_zero;
            if (div_by_zero) begin
                // Raw dividend is parked in the remainder half for HI.
                acc      <= {a, {WIDTH{1'b0}}};
                neg_lo_q <= 1'b0;
                neg_hi_q <= 1'b0;
            end else if (op_is_div(op_in)) begin
                acc      <= {{WIDTH{1'b0}}, mag_a};
                opnd     <= mag_b;
                neg_lo_q <= sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_hi_q <= sgn_op && a[WIDTH-1];
            end else begin
                acc      <= {{WIDTH{1'b0}}, mag_b};
                opnd     <= mag_a;
                neg_lo_q <= sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_hi_q <= 1'b0;
            end
        end else if (step) begin
            acc <= acc_nx;
        end
    end

    always_comb begin
        prod = neg_lo_q ? (-acc) : acc;
        quot = neg_lo_q ? (-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        rem  = neg_hi_q ? (-acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
        if (dz_q) begin
            res_hi = acc[2*WIDTH-1:WIDTH];
            res_lo = '1;
        end else if (is_div_q) begin
            res_hi = rem;
            res_lo = quot;
        end else begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/md_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start, op    one-cycle request and operation (accepted when not busy)
//   a, b         rs/rt operands; a is also the MTHI/MTLO data
//   mthi, mtlo   write a into HI/LO (ignored while busy)
//   busy         operation in flight (CALC and FIX)
//   done         one-cycle pulse after HI/LO were written by an operation
//   hi, lo       HI/LO registers
module md_seq
    import md_seq_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  cnt;
    logic              load;
    logic              step;
    logic              res_wr;
    logic              div_by_zero;
    logic [WIDTH-1:0]  res_hi;
    logic [WIDTH-1:0]  res_lo;

    md_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .step        (step),
        .op          (op),
        .a           (a),
        .b           (b),
        .div_by_zero (div_by_zero),
        .res_hi      (res_hi),
        .res_lo      (res_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // DONE accepts a new start just like IDLE, since busy is already low.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nx = div_by_zero ? ST_FIX : ST_CALC;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_nx = ST_FIX;
                end
            end
            ST_FIX:  state_nx = ST_DONE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == ST_CALC) || (state == ST_FIX);
        done   = (state == ST_DONE);
        load   = start && ((state == ST_IDLE) || (state == ST_DONE));
        step   = (state == ST_CALC);
        res_wr = (state == ST_FIX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (res_wr) begin
            hi <= res_hi;
            lo <= res_lo;
        end else if (!busy) begin
            if (mthi) begin
                hi <= a;
            end
            if (mtlo) begin
                lo <= a;
            end
        end
    end

endmodule
